// File: rtl/dsram_resp_if.sv
// dsram_resp request/response bus between the
// data-side master and the response unit.
interface dsram_resp_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/dsram_resp.sv
// dsram_resp: in-order response unit in front of a sync RAM.
// Optional head-of-queue wait: define DSRAM_RESP_DELAY_EN.
module dsram_resp #(
   parameter int RAM_AW = 16,
   parameter int DELAY  = 3
) (
   input  logic              clk,
   input  logic              rst,
   dsram_resp_if.slave       bus,
   output logic              ram_en,
   output logic [3:0]        ram_wen,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   logic [2:0]  count;
   logic        accept;
   logic        push;
   logic        pop;
   logic        head_ok;
   logic        s1_valid;
   logic        s1_wr;
   logic [3:0]  wen_mask;
   logic [31:0] fifo [4];
   logic [1:0]  wp;
   logic [1:0]  rp;
   logic [2:0]  occ;
   logic        unused_addr;

   assign unused_addr = ^bus.addr[31:RAM_AW+2];

   assign bus.addr_ok = !rst && (count < 3'd4);
   assign accept      = bus.req && bus.addr_ok;

   // byte-lane write mask; misaligned halfwords/words follow
   // the same lane rule, no fault is raised
   always_comb begin
      wen_mask = 4'b0000;
      unique case (bus.size)
         2'b00:   wen_mask = 4'b0001 << bus.addr[1:0];
         2'b01:   wen_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
         default: wen_mask = 4'b1111;
      endcase
   end

   assign ram_en    = accept;
   assign ram_wen   = (accept && bus.wr) ? wen_mask : 4'b0000;
   assign ram_addr  = accept ? bus.addr[RAM_AW+1:2] : '0;
   assign ram_wdata = accept ? bus.wdata : 32'h0;

   assign push = s1_valid;
   assign pop  = !rst && (occ != 3'd0) && head_ok;

   assign bus.data_ok = pop;
   assign bus.rdata   = pop ? fifo[rp] : 32'h0;

`ifdef DSRAM_RESP_DELAY_EN
   localparam int DW = $clog2(DELAY + 2);

   logic [DW-1:0] dly;
   logic          head_load;

   assign head_load = (push && occ == 3'd0) ||
                      (pop && (occ - 3'd1 + {2'b00, push}) != 3'd0);
   assign head_ok   = (dly == '0);

   // reload the wait on every new head, then count down
   always_ff @(posedge clk) begin
      if (rst) begin
         dly <= '0;
      end else if (head_load) begin
         dly <= DW'(DELAY);
      end else if (dly != '0) begin
         dly <= dly - 1'b1;
      end
   end
`else
   assign head_ok = 1'b1;
`endif

   // stage-1 tag: remembers what the RAM is answering next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_wr    <= 1'b0;
      end else begin
         s1_valid <= accept;
         s1_wr    <= bus.wr;
      end
   end

   // response storage; writes return a zero word
   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wp] <= s1_wr ? 32'h0 : ram_rdata;
      end
   end

   // fifo pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= 2'd0;
         rp  <= 2'd0;
         occ <= 3'd0;
      end else begin
         if (push) wp <= wp + 2'd1;
         if (pop)  rp <= rp + 2'd1;
         if (push && !pop)      occ <= occ + 3'd1;
         else if (!push && pop) occ <= occ - 3'd1;
      end
   end

   // outstanding requests, bounds the fifo at four entries
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 3'd0;
      end else if (accept && !pop) begin
         count <= count + 3'd1;
      end else if (!accept && pop) begin
         count <= count - 3'd1;
      end
   end

endmodule
